fsm_divider: RTL and testbench
==============================

// Module: fsm_divider
// PURPOSE
//   Sequential restoring divider FSM, the inverse of the shift-add multiplier.
//   Divides a 2*W-bit dividend by a W-bit divisor, one quotient bit per clock.
//   Returns a W-bit quotient and a W-bit remainder, or flags overflow / divide-by-zero.
//   Uses the same in_en/out_en pulse handshake as the multiplier, so a product can be
//   fed straight back for round-trip checking.
// PARAMETERS
//   W  8  operand width; dividend is 2*W bits, divisor/quotient/remainder are W bits
// PORTS
//   clk     in   1    single clock, all logic on rising edge
//   rst     in   1    synchronous, active-low reset (0 = reset, sampled on clk rise)
//   in_en   in   1    start pulse; dvdnd/dvsr sampled when in_en=1 and busy=0
//   dvdnd   in   2W   dividend
//   dvsr    in   W    divisor
//   quot    out  W    quotient, valid while out_en=1, held until next result
//   rmdr    out  W    remainder, valid while out_en=1, held until next result
//   ovf     out  1    quotient does not fit in W bits; valid with out_en
//   dz      out  1    divisor was zero; valid with out_en
//   busy    out  1    high from capture edge until out_en cycle ends
//   out_en  out  1    one-cycle result-valid pulse
// BEHAVIOUR
//   Reset (rst=0 at a clk edge):
//     - Enters IDLE; clears quot, rmdr, ovf, dz, busy, out_en and the iteration counter.
//     - Takes priority over every other event. An in-progress division is aborted and
//       no out_en is issued.
//   States: IDLE -> CHECK -> CALC (W cycles) -> DONE -> IDLE.
//   IDLE:
//     - in_en=1 at an edge latches dvdnd/dvsr, sets busy=1 and moves to CHECK.
//     - in_en=0 stays in IDLE.
//   CHECK (one cycle):
//     - dvsr==0: dz=1, ovf=0, quot=0, rmdr=0 -> DONE.
//     - dvdnd[2W-1:W] >= dvsr: ovf=1, dz=0, quot=0, rmdr=0 -> DONE.
//     - Otherwise: partial remainder = dvdnd[2W-1:W], counter=0 -> CALC.
//   CALC, one iteration per edge, MSB-first over dvdnd[W-1:0]:
//     - pr = {pr, next dividend bit}; pr is W+1 bits internally.
//     - If pr >= dvsr: pr -= dvsr and the quotient bit is 1; else the quotient bit is 0.
//     - After W iterations, quot and rmdr = pr[W-1:0] are loaded, ovf=dz=0 -> DONE.
//   DONE (one cycle):
//     - out_en=1 -> IDLE; busy drops together with out_en at the next edge.
//   Latency, counted from the capture edge E:
//     - Normal path: out_en is high in the cycle after edge E+W+1 (W=8: 9 edges).
//     - Error paths (dz/ovf): out_en is high after edge E+2.
//   Handshake and output-holding rules:
//     - in_en while busy=1 (including the DONE cycle) is ignored; it is not queued.
//     - Back-to-back: in_en in the first IDLE cycle after DONE is accepted.
//     - quot/rmdr/ovf/dz change only when loaded; otherwise they hold between results.
//   Arithmetic:
//     - Unsigned only.
//     - For non-error results: dvdnd == quot*dvsr + rmdr and rmdr < dvsr.
// TESTING
//   1. dvdnd=16'd25, dvsr=8'd5, in_en pulse one cycle -> 9 edges later out_en=1 for one
//      cycle; quot=5, rmdr=0, ovf=0, dz=0.
//   2. dvdnd=16'd1000, dvsr=8'd7 -> quot=142, rmdr=6.
//      Max-quotient boundary: 16'hFEFF / 8'hFF -> quot=255, rmdr=254, ovf=0.
//   3. 16'hFFFF / 8'hFF -> ovf=1, dz=0, quot=0, rmdr=0, out_en after edge E+2.
//      16'd100 / 8'd0 -> dz=1, ovf=0.
//   4. Start 1000/7; pulse in_en with 50/5 mid-CALC -> second request ignored; only one
//      out_en with quot=142, rmdr=6. Then 50/5 issued the cycle after DONE -> quot=10, rmdr=0.
//   5. Start 1000/7; assert rst=0 for one edge at iteration 4 -> busy=0, all outputs 0,
//      no out_en. A new 25/5 then completes normally.
//   6. Round trip: feed multiplier prdct=16'd25 with dvsr=8'd5 -> quot=5, rmdr=0.
//      Random sweep: check dvdnd == quot*dvsr + rmdr for all non-error cases.

Source files
------------

// File: rtl/fsm_divider.sv
// -----------------------------------------------------------------------------
// fsm_divider
//   Sequential restoring divider. Divides a 2*W-bit unsigned dividend by a
//   W-bit unsigned divisor, producing one quotient bit per clock. Results are
//   a W-bit quotient and a W-bit remainder, or an overflow / divide-by-zero
//   flag when the quotient cannot be formed. The start/result handshake is a
//   pair of single-cycle pulses (in_en / out_en), matching the shift-add
//   multiplier so a product can be fed straight back for round-trip checks.
//
//   Ports
//     clk     in   1    rising-edge clock
//     rst     in   1    synchronous active-low reset
//     in_en   in   1    start pulse, operands sampled when idle and not busy
//     dvdnd   in   2W   dividend
//     dvsr    in   W    divisor
//     quot    out  W    quotient, held until the next result is loaded
//     rmdr    out  W    remainder, held until the next result is loaded
//     ovf     out  1    quotient does not fit in W bits
//     dz      out  1    divisor was zero
//     busy    out  1    high from the capture edge until the out_en cycle ends
//     out_en  out  1    one-cycle result-valid pulse
//
//   Timing from the capture edge E:
//     normal path : CHECK at E+1, W CALC iterations at E+2..E+W+1, the last
//                   one loads the result and raises out_en.
//     error path  : CHECK at E+1 loads the flags, out_en rises at E+2.
// -----------------------------------------------------------------------------
module fsm_divider #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_en,
    input  logic [2*W-1:0]   dvdnd,
    input  logic [W-1:0]     dvsr,
    output logic [W-1:0]     quot,
    output logic [W-1:0]     rmdr,
    output logic             ovf,
    output logic             dz,
    output logic             busy,
    output logic             out_en
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_CALC  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. Returns {qbit, new_pr}.
    // The partial remainder is always below the divisor, so the shifted
    // value needs only W+1 bits and the result again fits in W+1 bits.
    function automatic logic [W+1:0] restore_step(
        input logic [W:0]   pr,
        input logic         din,
        input logic [W-1:0] d
    );
        logic [W:0] sh;
        logic [W:0] dx;
        sh = (pr << 1) | {{W{1'b0}}, din};
        dx = {1'b0, d};
        if (sh >= dx) begin
            restore_step = {1'b1, sh - dx};
        end else begin
            restore_step = {1'b0, sh};
        end
    endfunction

    state_t            state_r, state_s;

    logic [W-1:0]      dvd_hi_r, dvd_hi_s;
    logic [W-1:0]      dvd_lo_r, dvd_lo_s;    // shifted left, MSB feeds the next step
    logic [W-1:0]      dvsr_r,   dvsr_s;
    logic [W:0]        pr_r,     pr_s;
    logic [W-1:0]      qacc_r,   qacc_s;
    logic [CNT_W-1:0]  cnt_r,    cnt_s;

    logic [W-1:0]      quot_r,   quot_s;
    logic [W-1:0]      rmdr_r,   rmdr_s;
    logic              ovf_r,    ovf_s;
    logic              dz_r,     dz_s;
    logic              busy_r,   busy_s;
    logic              out_en_r, out_en_s;

    logic [W+1:0]      step_s;
    logic [W-1:0]      qshift_s;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, datapath and output-register next values
    always_comb begin
        state_s  = state_r;
        dvd_hi_s = dvd_hi_r;
        dvd_lo_s = dvd_lo_r;
        dvsr_s   = dvsr_r;
        pr_s     = pr_r;
        qacc_s   = qacc_r;
        cnt_s    = cnt_r;
        quot_s   = quot_r;
        rmdr_s   = rmdr_r;
        ovf_s    = ovf_r;
        dz_s     = dz_r;
        busy_s   = busy_r;
        out_en_s = out_en_r;

        step_s   = restore_step(pr_r, dvd_lo_r[W-1], dvsr_r);
        qshift_s = {qacc_r[W-2:0], step_s[W+1]};

        case (state_r)
            ST_IDLE: begin
                if (in_en && !busy_r) begin
                    dvd_hi_s = dvdnd[2*W-1:W];
                    dvd_lo_s = dvdnd[W-1:0];
                    dvsr_s   = dvsr;
                    busy_s   = 1'b1;
                    state_s  = ST_CHECK;
                end else begin
                    state_s  = ST_IDLE;
                end
            end

            ST_CHECK: begin
                if (dvsr_r == {W{1'b0}}) begin
                    dz_s    = 1'b1;
                    ovf_s   = 1'b0;
                    quot_s  = {W{1'b0}};
                    rmdr_s  = {W{1'b0}};
                    state_s = ST_DONE;
                end else if (dvd_hi_r >= dvsr_r) begin
                    // The upper half alone already holds at least one full
                    // divisor, so the quotient would need more than W bits.
                    ovf_s   = 1'b1;
                    dz_s    = 1'b0;
                    quot_s  = {W{1'b0}};
                    rmdr_s  = {W{1'b0}};
                    state_s = ST_DONE;
                end else begin
                    pr_s    = {1'b0, dvd_hi_r};
                    qacc_s  = {W{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_CALC;
                end
            end

            ST_CALC: begin
                pr_s     = step_s[W:0];
                qacc_s   = qshift_s;
                dvd_lo_s = {dvd_lo_r[W-2:0], 1'b0};
                if (cnt_r == CNT_LAST) begin
                    // Final iteration: publish the result and raise out_en
                    // on the same edge.
                    quot_s   = qshift_s;
                    rmdr_s   = step_s[W-1:0];
                    ovf_s    = 1'b0;
                    dz_s     = 1'b0;
                    out_en_s = 1'b1;
                    state_s  = ST_DONE;
                end else begin
                    cnt_s    = cnt_r + CNT_W'(1);
                    state_s  = ST_CALC;
                end
            end

            ST_DONE: begin
                // An error result arrives here with out_en still low and is
                // presented one cycle later; a computed result arrives with
                // out_en already high. Either way the out_en cycle ends by
                // dropping busy and returning to IDLE.
                if (out_en_r) begin
                    out_en_s = 1'b0;
                    busy_s   = 1'b0;
                    state_s  = ST_IDLE;
                end else begin
                    out_en_s = 1'b1;
                    state_s  = ST_DONE;
                end
            end

            default: begin
                busy_s   = 1'b0;
                out_en_s = 1'b0;
                state_s  = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            dvd_hi_r <= {W{1'b0}};
            dvd_lo_r <= {W{1'b0}};
            dvsr_r   <= {W{1'b0}};
            pr_r     <= {(W+1){1'b0}};
            qacc_r   <= {W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            quot_r   <= {W{1'b0}};
            rmdr_r   <= {W{1'b0}};
            ovf_r    <= 1'b0;
            dz_r     <= 1'b0;
            busy_r   <= 1'b0;
            out_en_r <= 1'b0;
        end else begin
            dvd_hi_r <= dvd_hi_s;
            dvd_lo_r <= dvd_lo_s;
            dvsr_r   <= dvsr_s;
            pr_r     <= pr_s;
            qacc_r   <= qacc_s;
            cnt_r    <= cnt_s;
            quot_r   <= quot_s;
            rmdr_r   <= rmdr_s;
            ovf_r    <= ovf_s;
            dz_r     <= dz_s;
            busy_r   <= busy_s;
            out_en_r <= out_en_s;
        end
    end

    assign quot   = quot_r;
    assign rmdr   = rmdr_r;
    assign ovf    = ovf_r;
    assign dz     = dz_r;
    assign busy   = busy_r;
    assign out_en = out_en_r;

endmodule

// File: tb/tb_fsm_divider.sv
// -----------------------------------------------------------------------------
// tb_fsm_divider
//   Scoreboard bench for fsm_divider (W=8). The stimulus process pushes the
//   hand-computed expected result and the cycle on which out_en must appear;
//   an independent monitor pops and compares whenever out_en is high.
// -----------------------------------------------------------------------------
module tb_fsm_divider;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_en = 1'b0;
    logic [15:0]   dvdnd = 16'd0;
    logic [7:0]    dvsr = 8'd0;
    logic [7:0]    quot;
    logic [7:0]    rmdr;
    logic          ovf;
    logic          dz;
    logic          busy;
    logic          out_en;

    fsm_divider #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .in_en  (in_en),
        .dvdnd  (dvdnd),
        .dvsr   (dvsr),
        .quot   (quot),
        .rmdr   (rmdr),
        .ovf    (ovf),
        .dz     (dz),
        .busy   (busy),
        .out_en (out_en)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge k, cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        eovf;
        logic        edz;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] recon;

    // Monitor: compare every result pulse against the scoreboard head.
    always @(negedge clk) begin
        if (rst && out_en) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_en: got quot=%0d rmdr=%0d ovf=%0d dz=%0d at cycle %0d, required no result",
                         quot, rmdr, ovf, dz, cyc);
            end else begin
                mon_e = sb.pop_front();
                if ({quot, rmdr, ovf, dz} !== {mon_e.q, mon_e.r, mon_e.eovf, mon_e.edz} || cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL result %0d/%0d: got quot=%0d rmdr=%0d ovf=%0d dz=%0d cycle=%0d, required quot=%0d rmdr=%0d ovf=%0d dz=%0d cycle=%0d",
                             mon_e.a, mon_e.b, quot, rmdr, ovf, dz, cyc,
                             mon_e.q, mon_e.r, mon_e.eovf, mon_e.edz, mon_e.due);
                end
                if (!mon_e.eovf && !mon_e.edz) begin
                    checks++;
                    recon = 16'(quot) * 16'(mon_e.b) + 16'(rmdr);
                    if (recon !== mon_e.a || rmdr >= mon_e.b) begin
                        errors++;
                        $display("FAIL identity %0d/%0d: got quot*dvsr+rmdr=%0d rmdr=%0d, required %0d with rmdr<%0d",
                                 mon_e.a, mon_e.b, recon, rmdr, mon_e.a, mon_e.b);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Pulse in_en for one cycle; optionally register the expected result.
    task automatic issue(input logic [15:0] a, input logic [7:0] b,
                         input logic [7:0] q, input logic [7:0] r,
                         input logic eo, input logic ed,
                         input bit push, output int cap);
        exp_t e;
        @(negedge clk);
        dvdnd = a;
        dvsr  = b;
        in_en = 1'b1;
        @(posedge clk);
        #1;
        cap   = cyc;
        in_en = 1'b0;
        if (push) begin
            e.a    = a;
            e.b    = b;
            e.q    = q;
            e.r    = r;
            e.eovf = eo;
            e.edz  = ed;
            e.due  = cap + ((eo || ed) ? 2 : 9);
            sb.push_back(e);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Wait (bounded) for the scoreboard to empty.
    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int cap;
        logic [7:0]  rb, rq, rr;
        logic [15:0] ra;
        logic [15:0] prdct;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_quot",   32'(quot),   32'd0);
        chk("reset_rmdr",   32'(rmdr),   32'd0);
        chk("reset_flags",  32'({ovf, dz}), 32'd0);
        chk("reset_busy",   32'(busy),   32'd0);
        chk("reset_out_en", 32'(out_en), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic division and busy/hold behaviour
        issue(16'd25, 8'd5, 8'd5, 8'd0, 1'b0, 1'b0, 1'b1, cap);
        wait_until(cap + 4);
        chk("busy_in_calc", 32'(busy), 32'd1);
        drain();
        repeat (5) @(negedge clk);
        chk("hold_quot", 32'(quot), 32'd5);
        chk("idle_busy", 32'(busy), 32'd0);

        issue(16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 1'b0, 1'b1, cap);
        drain();
        issue(16'hFEFF, 8'hFF, 8'd255, 8'd254, 1'b0, 1'b0, 1'b1, cap);
        drain();

        // Error paths
        issue(16'hFFFF, 8'hFF, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1, cap);
        drain();
        issue(16'd100, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, cap);
        drain();
        repeat (3) @(negedge clk);
        chk("hold_dz", 32'({dz, ovf}), 32'd2);

        // Requests while busy are dropped; back-to-back after DONE accepted
        issue(16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 1'b0, 1'b1, cap);
        wait_until(cap + 3);
        issue(16'd50, 8'd5, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, rq);
        wait_until(cap + 8);
        issue(16'd77, 8'd3, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, rq);
        issue(16'd50, 8'd5, 8'd10, 8'd0, 1'b0, 1'b0, 1'b1, rq);
        drain();

        // Reset mid-calculation aborts with no result
        issue(16'd1000, 8'd7, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, cap);
        wait_until(cap + 5);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_busy",   32'(busy),   32'd0);
        chk("abort_quot",   32'(quot),   32'd0);
        chk("abort_rmdr",   32'(rmdr),   32'd0);
        chk("abort_out_en", 32'(out_en), 32'd0);
        repeat (14) @(negedge clk);
        issue(16'd25, 8'd5, 8'd5, 8'd0, 1'b0, 1'b0, 1'b1, cap);
        drain();

        // Round trip from a multiplier product, then a constructed sweep
        prdct = 16'd5 * 16'd5;
        issue(prdct, 8'd5, 8'd5, 8'd0, 1'b0, 1'b0, 1'b1, cap);
        drain();
        for (int i = 0; i < 10; i++) begin
            rb = 8'($urandom_range(1, 255));
            rq = 8'($urandom_range(0, 255));
            rr = 8'($urandom_range(0, 32'(rb) - 1));
            ra = 16'(rq) * 16'(rb) + 16'(rr);
            issue(ra, rb, rq, rr, 1'b0, 1'b0, 1'b1, cap);
            drain();
        end

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
